// File: rtl/rx_fifo_merge_pkg.sv
// Shared types and constants for the RX FIFO merger.
package rx_fifo_merge_pkg;

    // Arbitration FSM: IDLE picks a channel, HOLD streams from it
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Per-channel word counter width
    localparam int CNT_W  = 16;
    // Widest supported channel count and the index width it needs
    localparam int MAX_CH = 16;
    localparam int IDX_W  = 4;

    // Index of the set bit in a one-hot vector (0 when none set)
    function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_CH-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++)
            if (oh[i]) idx = idx | IDX_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rx_fifo_merge_arbiter.sv
// Combinational channel picker: fixed priority (lowest index) or
// round-robin starting just after the last granted channel.
module rr_arbiter
    import rx_fifo_merge_pkg::*;
#(
    parameter int NCH = 5
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] last,
    input  logic             rr,
    output logic [NCH-1:0]   grant
);

    // Walk all NCH slots once; fixed mode starts at 0, rr mode at last+1
    always_comb begin
        int   idx;
        logic hit;
        grant = '0;
        hit   = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = rr ? (int'(last) + k) % NCH : k - 1;
            if (!hit && req[idx]) begin
                grant[idx] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_fifo_merge.sv
// Merges NCH first-word-fall-through source FIFOs into one FWFT stream.
// A channel is held until it empties, is disabled, or hits the burst limit;
// each re-arbitration costs one idle cycle.
module rx_fifo_merge
    import rx_fifo_merge_pkg::*;
#(
    parameter int NCH = 5,
    parameter int DW  = 32,
    parameter int BW  = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_B,
    input  logic [NCH-1:0]       CONF_EN,
    input  logic                 CONF_RR,
    input  logic [BW-1:0]        CONF_MAX_BURST,
    input  logic                 CNT_CLR,
    input  logic [NCH-1:0]       CH_EMPTY,
    input  logic [NCH*DW-1:0]    CH_DATA,
    output logic [NCH-1:0]       CH_READ,
    input  logic                 FIFO_READ_NEXT_IN,
    output logic                 FIFO_EMPTY_OUT,
    output logic [DW-1:0]        FIFO_DATA_OUT,
    output logic [NCH-1:0]       GRANT,
    output logic [NCH*CNT_W-1:0] WORD_CNT,
    output logic                 READ_ERR
);

    state_t           state_q, state_d;
    logic [NCH-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [BW-1:0]    burst_q, burst_d, burst_inc;
    logic [NCH-1:0]   req, arb_grant;
    logic             granted_req, rd_fire, err_hit, burst_done;

    assign req         = ~CH_EMPTY & CONF_EN;
    // Only a live request on the held channel makes data visible, so a
    // disable or drain mid-burst blocks reads in the same cycle
    assign granted_req = (state_q == ST_HOLD) && (|(req & grant_q));
    assign rd_fire     = FIFO_READ_NEXT_IN & granted_req;
    assign err_hit     = FIFO_READ_NEXT_IN & ~granted_req;
    assign burst_inc   = burst_q + BW'(1);
    assign burst_done  = (CONF_MAX_BURST != '0) && (burst_inc == CONF_MAX_BURST);

    assign FIFO_EMPTY_OUT = ~granted_req;
    assign CH_READ        = grant_q & {NCH{rd_fire}};
    assign GRANT          = grant_q;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req   (req),
        .last  (last_q),
        .rr    (CONF_RR),
        .grant (arb_grant)
    );

    // Output data mux; zero while nothing is granted
    always_comb begin
        FIFO_DATA_OUT = '0;
        for (int i = 0; i < NCH; i++)
            if (grant_q[i]) FIFO_DATA_OUT = FIFO_DATA_OUT | CH_DATA[i*DW +: DW];
    end

    // Next-state: arbitrate in IDLE, release in HOLD on drain/disable/limit
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_HOLD;
                    grant_d = arb_grant;
                    last_d  = oh2idx(MAX_CH'(arb_grant));
                    burst_d = '0;
                end
            end
            ST_HOLD: begin
                if (!granted_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (rd_fire) begin
                    burst_d = burst_inc;
                    if (burst_done) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // FSM, grant, round-robin pointer and burst count registers
    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NCH - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    // Sticky downstream underflow flag; clear beats a new error
    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B)   READ_ERR <= 1'b0;
        else if (CNT_CLR) READ_ERR <= 1'b0;
        else if (err_hit) READ_ERR <= 1'b1;
    end

    // Per-channel wrapping word counters; clear beats a same-cycle read
    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
            if (!BUS_RST_B)      cnt_q <= '0;
            else if (CNT_CLR)    cnt_q <= '0;
            else if (CH_READ[i]) cnt_q <= cnt_q + CNT_W'(1);
        end
        assign WORD_CNT[i*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_rx_fifo_merge.sv
// Bench for rx_fifo_merge: queue-based sources, behavioural model,
// per-cycle compare plus directed scenarios with literal expectations.
module tb_rx_fifo_merge;
    localparam int NCH = 5;
    localparam int DW  = 32;
    localparam int BW  = 8;
    localparam int CW  = 16;

    logic              BUS_CLK = 1'b0;
    logic              BUS_RST_B;
    logic [NCH-1:0]    CONF_EN;
    logic              CONF_RR;
    logic [BW-1:0]     CONF_MAX_BURST;
    logic              CNT_CLR;
    logic [NCH-1:0]    CH_EMPTY;
    logic [NCH*DW-1:0] CH_DATA;
    logic [NCH-1:0]    CH_READ;
    logic              FIFO_READ_NEXT_IN;
    logic              FIFO_EMPTY_OUT;
    logic [DW-1:0]     FIFO_DATA_OUT;
    logic [NCH-1:0]    GRANT;
    logic [NCH*CW-1:0] WORD_CNT;
    logic              READ_ERR;

    always #5 BUS_CLK = ~BUS_CLK;

    rx_fifo_merge #(.NCH(NCH), .DW(DW), .BW(BW)) dut (
        .BUS_CLK           (BUS_CLK),
        .BUS_RST_B         (BUS_RST_B),
        .CONF_EN           (CONF_EN),
        .CONF_RR           (CONF_RR),
        .CONF_MAX_BURST    (CONF_MAX_BURST),
        .CNT_CLR           (CNT_CLR),
        .CH_EMPTY          (CH_EMPTY),
        .CH_DATA           (CH_DATA),
        .CH_READ           (CH_READ),
        .FIFO_READ_NEXT_IN (FIFO_READ_NEXT_IN),
        .FIFO_EMPTY_OUT    (FIFO_EMPTY_OUT),
        .FIFO_DATA_OUT     (FIFO_DATA_OUT),
        .GRANT             (GRANT),
        .WORD_CNT          (WORD_CNT),
        .READ_ERR          (READ_ERR)
    );

    // Source FIFOs and what was driven on each data lane this cycle
    logic [DW-1:0] srcq [NCH][$];
    logic [DW-1:0] drv_data [NCH];
    bit            refill [NCH];

    // Model state
    bit m_hold;
    int m_g, m_last, m_burst;
    int m_cnt [NCH];
    bit m_err;
    // Model outputs for the current cycle
    logic [NCH-1:0] m_req, e_grant, e_read;
    logic           e_empty;
    logic [DW-1:0]  e_data;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    logic [NCH-1:0] cap_read, cap_grant;
    logic [DW-1:0]  cap_data;
    logic           cap_empty;

    int rlog[$];
    logic [DW-1:0] dlog[$];
    int glog[$];
    int exp_rlog [9] = '{-1, 0, 0, 0, -1, -1, 3, 3, -1};
    logic [DW-1:0] exp_dlog [5] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
                                    32'hD000_0000, 32'hD000_0001};
    int exp_glog [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ohidx(input logic [NCH-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NCH; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_hold = 0; m_g = 0; m_last = NCH - 1; m_burst = 0; m_err = 0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    endtask

    task automatic drive_src();
        for (int i = 0; i < NCH; i++) begin
            if (srcq[i].size() != 0) drv_data[i] = srcq[i][0];
            else                     drv_data[i] = $urandom;
            CH_DATA[i*DW +: DW] = drv_data[i];
            CH_EMPTY[i]         = (srcq[i].size() == 0);
        end
    endtask

    // What the outputs must be this cycle
    task automatic model_comb();
        for (int i = 0; i < NCH; i++) m_req[i] = (srcq[i].size() != 0) && CONF_EN[i];
        e_grant = m_hold ? (NCH'(1) << m_g) : '0;
        e_empty = !(m_hold && m_req[m_g]);
        e_data  = m_hold ? drv_data[m_g] : '0;
        e_read  = (FIFO_READ_NEXT_IN && !e_empty) ? e_grant : '0;
    endtask

    // State after the clock edge
    task automatic model_adv();
        bit rd_ok;
        int pick;
        rd_ok = (e_read != '0);
        if (rd_ok) begin
            srcq[m_g].delete(0);
            if (refill[m_g]) srcq[m_g].push_back($urandom);
        end
        if (CNT_CLR) begin
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            m_err = 0;
        end else begin
            if (rd_ok) m_cnt[m_g] = (m_cnt[m_g] + 1) % 65536;
            if (FIFO_READ_NEXT_IN && e_empty) m_err = 1;
        end
        if (!m_hold) begin
            if (m_req != '0) begin
                pick = -1;
                if (CONF_RR) begin
                    for (int off = 1; off <= NCH; off++)
                        if (pick < 0 && m_req[(m_last + off) % NCH]) pick = (m_last + off) % NCH;
                end else begin
                    for (int c = NCH - 1; c >= 0; c--) if (m_req[c]) pick = c;
                end
                m_hold = 1; m_g = pick; m_last = pick; m_burst = 0;
            end
        end else if (!m_req[m_g]) begin
            m_hold = 0;
        end else if (rd_ok) begin
            m_burst = (m_burst + 1) % 256;
            if (CONF_MAX_BURST != 0 && m_burst == int'(CONF_MAX_BURST)) m_hold = 0;
        end
    endtask

    // One clock: called at posedge+1, returns at next posedge+1
    task automatic tick();
        drive_src();
        model_comb();
        #1;
        cap_read = CH_READ; cap_grant = GRANT; cap_data = FIFO_DATA_OUT; cap_empty = FIFO_EMPTY_OUT;
        @(posedge BUS_CLK);
        if (BUS_RST_B) model_adv();
        #1;
    endtask

    task automatic do_reset();
        BUS_RST_B = 1'b0;
        model_reset();
        drive_src();
        model_comb();
        @(posedge BUS_CLK);
        #1;
        BUS_RST_B = 1'b1;
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NCH; i++) begin srcq[i].delete(); refill[i] = 0; end
    endtask

    // Per-cycle compare against the model
    always @(negedge BUS_CLK) begin
        if (chk_en) begin
            chk("empty", FIFO_EMPTY_OUT, e_empty);
            chk("data", FIFO_DATA_OUT, e_data);
            chk("grant", GRANT, e_grant);
            chk("ch_read", CH_READ, e_read);
            chk("read_err", READ_ERR, m_err);
            for (int i = 0; i < NCH; i++)
                chk($sformatf("word_cnt%0d", i), WORD_CNT[i*CW +: CW], 64'(m_cnt[i]));
        end
    end

    initial begin
        BUS_RST_B = 1'b1;
        CONF_EN = '1; CONF_RR = 0; CONF_MAX_BURST = '0; CNT_CLR = 0;
        FIFO_READ_NEXT_IN = 0; CH_EMPTY = '1; CH_DATA = '0;
        clear_srcs();
        model_reset();
        #1 BUS_RST_B = 1'b0;
        // Reset state, with a pending source and a read request
        srcq[0].push_back(32'h1234_5678);
        FIFO_READ_NEXT_IN = 1;
        drive_src();
        #1;
        chk("rst_ch_read", CH_READ, 0);
        chk("rst_empty", FIFO_EMPTY_OUT, 1);
        chk("rst_data", FIFO_DATA_OUT, 0);
        chk("rst_grant", GRANT, 0);
        chk("rst_err", READ_ERR, 0);
        chk("rst_cnt", WORD_CNT, 0);
        clear_srcs();
        FIFO_READ_NEXT_IN = 0;
        drive_src();
        model_comb();
        @(posedge BUS_CLK);
        #1;
        BUS_RST_B = 1'b1;
        chk_en = 1;

        // Fixed priority: channel 0 drained, idle, then channel 3
        for (int k = 0; k < 3; k++) srcq[0].push_back(32'hA000_0000 + k);
        for (int k = 0; k < 2; k++) srcq[3].push_back(32'hD000_0000 + k);
        FIFO_READ_NEXT_IN = 1;
        for (int t = 0; t < 9; t++) begin
            tick();
            rlog.push_back(ohidx(cap_read));
            if (cap_read != '0) dlog.push_back(cap_data);
        end
        for (int t = 0; t < 9; t++) chk($sformatf("fixed_rlog%0d", t), 64'(rlog[t]), 64'(exp_rlog[t]));
        chk("fixed_dlog_n", dlog.size(), 5);
        for (int t = 0; t < 5 && t < dlog.size(); t++) chk($sformatf("fixed_dlog%0d", t), dlog[t], exp_dlog[t]);
        chk("fixed_cnt0", WORD_CNT[0*CW +: CW], 3);
        chk("fixed_cnt3", WORD_CNT[3*CW +: CW], 2);
        chk("fixed_err", READ_ERR, 1);

        // Round robin, burst 2, four words per channel
        FIFO_READ_NEXT_IN = 0;
        do_reset();
        CONF_RR = 1; CONF_MAX_BURST = 8'd2;
        for (int i = 0; i < NCH; i++) for (int k = 0; k < 4; k++) srcq[i].push_back($urandom);
        FIFO_READ_NEXT_IN = 1;
        cap_grant = '0;
        begin
            logic [NCH-1:0] prev;
            prev = '0;
            for (int t = 0; t < 32; t++) begin
                tick();
                if (cap_grant != '0 && prev == '0) glog.push_back(ohidx(cap_grant));
                prev = cap_grant;
            end
        end
        chk("rr_glog_n", glog.size(), 10);
        for (int t = 0; t < 10 && t < glog.size(); t++) chk($sformatf("rr_glog%0d", t), 64'(glog[t]), 64'(exp_glog[t]));
        for (int i = 0; i < NCH; i++) chk($sformatf("rr_cnt%0d", i), WORD_CNT[i*CW +: CW], 4);

        // Disable mid-burst
        CONF_RR = 0; CONF_MAX_BURST = '0; CNT_CLR = 1; FIFO_READ_NEXT_IN = 0;
        tick();
        CNT_CLR = 0;
        for (int k = 0; k < 6; k++) srcq[2].push_back($urandom);
        FIFO_READ_NEXT_IN = 1;
        tick(); tick(); tick();
        chk("dis_grant_before", GRANT, 5'b00100);
        CONF_EN[2] = 1'b0;
        tick();
        chk("dis_ch_read", cap_read, 0);
        chk("dis_empty", cap_empty, 1);
        chk("dis_grant_after", GRANT, 0);
        CONF_EN = '1;

        // Read with everything empty
        clear_srcs();
        FIFO_READ_NEXT_IN = 0; CNT_CLR = 1;
        tick(); tick();
        CNT_CLR = 0; FIFO_READ_NEXT_IN = 1;
        tick();
        chk("err_ch_read", cap_read, 0);
        chk("err_set", READ_ERR, 1);
        FIFO_READ_NEXT_IN = 0; CNT_CLR = 1;
        tick();
        chk("err_clr", READ_ERR, 0);
        CNT_CLR = 0;

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 35) begin
                int c;
                c = $urandom_range(0, NCH - 1);
                if (srcq[c].size() < 8) srcq[c].push_back($urandom);
            end
            if ($urandom_range(0, 99) < 5)  CONF_EN = NCH'($urandom) | NCH'($urandom);
            if ($urandom_range(0, 99) < 3)  CONF_RR = ~CONF_RR;
            if ($urandom_range(0, 99) < 3)  CONF_MAX_BURST = BW'($urandom_range(0, 3));
            FIFO_READ_NEXT_IN = ($urandom_range(0, 99) < 75);
            CNT_CLR = ($urandom_range(0, 99) < 2);
            tick();
        end
        CNT_CLR = 0; CONF_EN = '1;

        // Counter wrap on channel 1 and clear-beats-read
        clear_srcs();
        FIFO_READ_NEXT_IN = 0; CONF_RR = 0; CONF_MAX_BURST = '0; CNT_CLR = 1;
        tick(); tick();
        CNT_CLR = 0;
        srcq[1].push_back($urandom);
        refill[1] = 1;
        tick();
        FIFO_READ_NEXT_IN = 1;
        for (int n = 0; n < 65537; n++) tick();
        FIFO_READ_NEXT_IN = 0;
        tick();
        chk("wrap_cnt1", WORD_CNT[1*CW +: CW], 16'h0001);
        FIFO_READ_NEXT_IN = 1; CNT_CLR = 1;
        tick();
        chk("clr_read_seen", cap_read, 5'b00010);
        chk("clr_wins", WORD_CNT[1*CW +: CW], 0);
        CNT_CLR = 0; FIFO_READ_NEXT_IN = 0;
        clear_srcs();
        tick();

        // Asynchronous reset mid-burst, then RR restart at channel 0
        CONF_RR = 1;
        for (int i = 0; i < NCH; i++) for (int k = 0; k < 4; k++) srcq[i].push_back($urandom);
        FIFO_READ_NEXT_IN = 1;
        tick(); tick(); tick();
        chk("arst_mid_burst", (GRANT != '0) && (WORD_CNT != '0), 1);
        #2;
        BUS_RST_B = 1'b0;
        model_reset();
        drive_src();
        model_comb();
        #1;
        chk("arst_ch_read", CH_READ, 0);
        chk("arst_empty", FIFO_EMPTY_OUT, 1);
        chk("arst_data", FIFO_DATA_OUT, 0);
        chk("arst_grant", GRANT, 0);
        chk("arst_cnt", WORD_CNT, 0);
        chk("arst_err", READ_ERR, 0);
        @(posedge BUS_CLK);
        #1;
        BUS_RST_B = 1'b1;
        tick();
        chk("arst_rr_restart", GRANT, 5'b00001);
        tick();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
